// File: rtl/mont_io_loader.sv
// Streams three 1024-bit operands in as 32-bit words, pulses the Montgomery multiplier, then streams the result out.
// Optional MONT_LOADER_KEEP_M_EN adds keep_m to reuse the previous modulus and skip LOAD_M.
module mont_io_loader (
    input  logic          clk,
    input  logic          resetn,
`ifdef MONT_LOADER_KEEP_M_EN
    input  logic          keep_m,
`endif
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_ready,
    output logic          mm_start,
    output logic [1023:0] mm_a,
    output logic [1023:0] mm_b,
    output logic [1023:0] mm_m,
    input  logic [1023:0] mm_result,
    input  logic          mm_done,
    output logic          out_valid,
    output logic [31:0]   out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy
);

    localparam int unsigned OP_W   = 1024;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned IDX_W  = 10;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(31);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_M,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q;
    logic                mm_start_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                busy_q;
    logic [WORD_W-1:0]   out_data_q;
    logic [OP_W-1:0]     a_q, b_q, m_q, res_q;
    logic                accept;
    logic                out_hs;
    logic                capture;
    logic                skip_m;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;

`ifdef MONT_LOADER_KEEP_M_EN
    logic                keep_q;
    assign skip_m = keep_q;
`else
    assign skip_m = 1'b0;
`endif

    assign accept = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;
    assign wr_idx = {cnt_q, 5'b00000};
    assign rd_idx = {cnt_d, 5'b00000};

    // Next-state and word counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_LOAD_A: if (accept) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_WORD) state_d = S_LOAD_B;
            end
            S_LOAD_B: if (accept) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_WORD) state_d = skip_m ? S_START : S_LOAD_M;
            end
            S_LOAD_M: if (accept) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_WORD) state_d = S_START;
            end
            // mm_done is deliberately not looked at here
            S_START: state_d = S_WAIT;
            S_WAIT: if (mm_done) begin
                capture = 1'b1;
                state_d = S_DRAIN;
            end
            S_DRAIN: if (out_hs) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_WORD) state_d = S_LOAD_A;
            end
            default: begin
                state_d = S_LOAD_A;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered control outputs derived from next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_LOAD_A;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            mm_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B) || (state_d == S_LOAD_M);
            mm_start_q  <= (state_d == S_START);
            out_valid_q <= (state_d == S_DRAIN);
            out_last_q  <= (state_d == S_DRAIN) && (cnt_d == LAST_WORD);
            busy_q      <= !((state_d == S_LOAD_A) && (cnt_d == '0));
        end
    end

    // Operand assembly, result capture and output word register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            res_q      <= '0;
            out_data_q <= '0;
`ifdef MONT_LOADER_KEEP_M_EN
            keep_q     <= 1'b0;
`endif
        end else begin
            if (accept && state_q == S_LOAD_A) a_q[wr_idx +: WORD_W] <= in_data;
            if (accept && state_q == S_LOAD_B) b_q[wr_idx +: WORD_W] <= in_data;
            if (accept && state_q == S_LOAD_M) m_q[wr_idx +: WORD_W] <= in_data;
`ifdef MONT_LOADER_KEEP_M_EN
            if (accept && state_q == S_LOAD_A && cnt_q == '0) keep_q <= keep_m;
`endif
            if (capture) begin
                res_q      <= mm_result;
                out_data_q <= mm_result[WORD_W-1:0];
            end else if (state_q == S_DRAIN && out_hs) begin
                out_data_q <= res_q[rd_idx +: WORD_W];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign mm_start  = mm_start_q;
    assign mm_a      = a_q;
    assign mm_b      = b_q;
    assign mm_m      = m_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
